io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Two-master arbiter for the memory-mapped I/O bus of the multicycle MIPS system. It shares one peripheral bus (active-low chip enable, write enable, 11-bit address, 32-bit data) between the CPU's load/store path (master 0) and a secondary master such as a debug or loader engine (master 1). Grants are round-robin and each grant lasts exactly one transaction. Bus strobes are driven from registers, and a per-master done pulse returns read data.

## Interface
- ADDR_W, 11, bus address width
- DATA_W, 32, bus data width
- ACCESS_CYCLES, 1, cycles the bus strobe stays asserted per transaction (legal range 1..15)

- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  transaction request from master 0 / 1, level
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  target address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  master owns the bus (ACCESS state)
- done0 / done1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid while done0 or done1 is high
- bus_nce  out  1  peripheral chip enable, active-low
- bus_we  out  1  peripheral write enable
- bus_addr  out  ADDR_W  peripheral address
- bus_data  out  DATA_W  peripheral write data
- bus_rdata  in  DATA_W  peripheral read data, combinational from the bus
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, ACCESS, DONE. Encoding is free.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that master.
  - If both are high, grant the master that was not granted last (`last` register).
- On a grant:
  - Latch we/addr/wdata of the winner into the bus registers.
  - Set bus_nce=0 and the matching gnt.
  - Load the access counter with ACCESS_CYCLES-1.
  - Update `last` to the winner.
  - Go to ACCESS.
- ACCESS:
  - Bus registers are held constant. Requester inputs are ignored after the latch.
  - If counter ≠ 0, decrement it.
  - If counter = 0:
    - Capture bus_rdata into rdata (writes capture too, so the value is don't-care).
    - Set bus_nce=1, bus_we=0, clear gnt, raise the winner's done.
    - Go to DONE.
- DONE:
  - done is high for exactly this cycle.
  - Unconditionally return to IDLE. No arbitration happens in DONE.
- A requester that sees done must drop req in the DONE cycle or the following IDLE cycle. A req still high in IDLE is treated as a new transaction.
- bus_addr and bus_data keep their last values when idle. Only bus_nce qualifies them.
- gnt0 and gnt1 are never high together. The same holds for done0 and done1.
- rdata holds its value until the next capture.

## Timing
- Reset values:
  - bus_nce=1, bus_we=0, bus_addr=0, bus_data=0, rdata=0
  - gnt0=gnt1=0, done0=done1=0, busy=0
  - state IDLE, `last`=1, so master 0 wins the first tie.
- Reset is asynchronous. Asserting it mid-ACCESS immediately deasserts bus_nce and gnt. The transaction is dropped and no done is issued.
- All outputs are registered. There are no combinational paths from req to bus.
- Request at edge N (seen in IDLE):
  - bus_nce=0 from edge N+1 for ACCESS_CYCLES cycles.
  - done is high in the cycle after the last ACCESS cycle.
  - Transaction period is ACCESS_CYCLES+2 cycles, IDLE cycle included.
- Writes: the peripheral samples on every edge while bus_nce=0. With ACCESS_CYCLES>1 the same data is rewritten, which is harmless.
- Reads: bus_rdata is sampled on the edge that leaves ACCESS, i.e. the last strobed cycle.
- Continuous contention (both reqs held) strictly alternates 0,1,0,1… with no starvation.

## Test plan
1. **Reset defaults:** hold nrst=0 for 3 cycles, then release with all req=0 → bus_nce=1, gnt/done=0, busy=0, bus_addr=0; remains idle for 10 cycles.
2. **Single write, ACCESS_CYCLES=1:** req0=1, we0=1, addr0=0, wdata0=0x000003A5 → one cycle later bus_nce=0, bus_we=1, bus_addr=0, bus_data=0x3A5, gnt0=1; next cycle done0=1, bus_nce=1. A downstream output port at addr 0 reads 0x3A5.
3. **Read, ACCESS_CYCLES=3:** req1=1, we1=0, addr1=0x004, bus_rdata=0xDEADBEEF → bus_nce low for exactly 3 cycles; done1 pulses once with rdata=0xDEADBEEF; gnt0 stays 0 throughout.
4. **Tie after reset and sustained contention:** req0=req1=1 with both held for 4 transactions → grant order 0,1,0,1; done pulses alternate; period is 3 cycles each with ACCESS_CYCLES=1.
5. **Late request during transaction:** req0 is granted; req1 rises mid-ACCESS with addr1=0x010 → master 1 is granted in the IDLE after done0; addr0 stays on the bus until then; master 1's inputs are latched only at its own grant.
6. **Reset mid-ACCESS, ACCESS_CYCLES=4:** assert nrst low during the 2nd ACCESS cycle → bus_nce=1 and gnt=0 immediately, no done pulse; after release, a tied request grants master 0 first.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for the memory-mapped I/O bus.
// One grant = one transaction; every bus strobe and response comes from a flop.
module io_bus_arbiter #(
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_nce,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              win;
    logic [3:0]        cnt_q, cnt_d;
    logic              bus_nce_q, bus_nce_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            bus_nce_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            rdata_q    <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            bus_nce_q  <= bus_nce_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            rdata_q    <= rdata_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        bus_nce_d  = bus_nce_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        rdata_d    = rdata_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        // On a tie the master that did not win last time goes next.
        win        = (req0 && req1) ? ~last_q : req1;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d    = win;
                    last_d     = win;
                    bus_we_d   = win ? we1 : we0;
                    bus_addr_d = win ? addr1 : addr0;
                    bus_data_d = win ? wdata1 : wdata0;
                    bus_nce_d  = 1'b0;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    cnt_d      = CNT_LOAD;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d   = bus_rdata;
                    bus_nce_d = 1'b1;
                    bus_we_d  = 1'b0;
                    gnt0_d    = 1'b0;
                    gnt1_d    = 1'b0;
                    done0_d   = ~owner_q;
                    done1_d   = owner_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata    = rdata_q;
    assign bus_nce  = bus_nce_q;
    assign bus_we   = bus_we_q;
    assign bus_addr = bus_addr_q;
    assign bus_data = bus_data_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: three instances (ACCESS_CYCLES 1, 3, 4) share one clock;
// done pulses are matched against an expected queue by a separate monitor.
module tb_io_bus_arbiter;
    logic        clk;
    logic        nrst   [3];
    logic        req0   [3];
    logic        req1   [3];
    logic        we0    [3];
    logic        we1    [3];
    logic [10:0] addr0  [3];
    logic [10:0] addr1  [3];
    logic [31:0] wdata0 [3];
    logic [31:0] wdata1 [3];
    logic        gnt0   [3];
    logic        gnt1   [3];
    logic        done0  [3];
    logic        done1  [3];
    logic [31:0] rdata  [3];
    logic        bus_nce[3];
    logic        bus_we [3];
    logic [10:0] bus_addr[3];
    logic [31:0] bus_data[3];
    logic [31:0] brd    [3];
    logic        busy   [3];

    // Entry layout: {instance[1:0], master, check_rdata, rdata[31:0]}
    logic [35:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] port0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        io_bus_arbiter #(
            .ADDR_W(11), .DATA_W(32),
            .ACCESS_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clk(clk), .nrst(nrst[g]),
            .req0(req0[g]), .req1(req1[g]), .we0(we0[g]), .we1(we1[g]),
            .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
            .gnt0(gnt0[g]), .gnt1(gnt1[g]), .done0(done0[g]), .done1(done1[g]),
            .rdata(rdata[g]), .bus_nce(bus_nce[g]), .bus_we(bus_we[g]),
            .bus_addr(bus_addr[g]), .bus_data(bus_data[g]), .bus_rdata(brd[g]),
            .busy(busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output port at address 0 downstream of instance 0.
    always @(posedge clk) begin
        if (!bus_nce[0] && bus_we[0] && bus_addr[0] == 11'd0) port0 <= bus_data[0];
    end

    function automatic logic [35:0] mk(input int inst, input logic m, input logic chk,
                                       input logic [31:0] rd);
        return {2'(inst), m, chk, rd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs(input int i);
        req0[i] = 0; req1[i] = 0; we0[i] = 0; we1[i] = 0;
        addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
    endtask

    always @(negedge clk) begin
        logic [35:0] e;
        logic [35:0] got;
        for (int i = 0; i < 3; i++) begin
            if (done0[i] && done1[i]) begin
                total++; bad++;
                $display("FAIL done_exclusive: inst %0d got both done high expected one", i);
            end else if (done0[i] || done1[i]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: inst %0d master %0d got done expected none",
                             i, done1[i]);
                end else begin
                    e   = exp_q.pop_front();
                    got = {2'(i), done1[i], e[32], (e[32] ? rdata[i] : e[31:0])};
                    if (got !== e) begin
                        bad++;
                        $display("FAIL done_match: got %h expected %h", got, e);
                    end
                end
            end
            if (gnt0[i] && gnt1[i]) begin
                total++; bad++;
                $display("FAIL gnt_exclusive: inst %0d got both gnt high expected one", i);
            end
        end
    end

    initial begin
        int nce_low, ndone, ng, g0_seen;
        int order[4];
        int gcyc[4];

        // Reset defaults
        for (int i = 0; i < 3; i++) begin
            nrst[i] = 1'b0;
            clear_inputs(i);
        end
        brd[0] = 32'h0; brd[1] = 32'hDEADBEEF; brd[2] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_nce", {31'd0, bus_nce[0]}, 32'd1);
        check("rst_gnt_done", {28'd0, gnt0[0], gnt1[0], done0[0], done1[0]}, 32'd0);
        for (int i = 0; i < 3; i++) nrst[i] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_busy", {31'd0, busy[0]}, 32'd0);
        end
        check("idle_nce", {31'd0, bus_nce[0]}, 32'd1);
        check("idle_addr", {21'd0, bus_addr[0]}, 32'd0);
        check("idle_data", bus_data[0], 32'd0);
        check("idle_rdata", rdata[0], 32'd0);

        // Single write, ACCESS_CYCLES=1
        req0[0] = 1; we0[0] = 1; addr0[0] = 11'd0; wdata0[0] = 32'h3A5;
        exp_q.push_back(mk(0, 1'b0, 1'b0, 32'h0));
        @(negedge clk);
        check("wr_nce", {31'd0, bus_nce[0]}, 32'd0);
        check("wr_we", {31'd0, bus_we[0]}, 32'd1);
        check("wr_addr", {21'd0, bus_addr[0]}, 32'd0);
        check("wr_data", bus_data[0], 32'h3A5);
        check("wr_gnt", {30'd0, gnt0[0], gnt1[0]}, 32'd2);
        check("wr_busy", {31'd0, busy[0]}, 32'd1);
        req0[0] = 0;
        @(negedge clk);
        check("wr_done_nce", {31'd0, bus_nce[0]}, 32'd1);
        check("wr_done_we", {31'd0, bus_we[0]}, 32'd0);
        check("wr_done_gnt", {31'd0, gnt0[0]}, 32'd0);
        check("wr_port0", port0, 32'h3A5);
        @(negedge clk);

        // Read, ACCESS_CYCLES=3
        req1[1] = 1; we1[1] = 0; addr1[1] = 11'h004;
        exp_q.push_back(mk(1, 1'b1, 1'b1, 32'hDEADBEEF));
        nce_low = 0; ndone = 0; g0_seen = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("rd_addr", {21'd0, bus_addr[1]}, 32'h004);
                check("rd_we", {31'd0, bus_we[1]}, 32'd0);
                req1[1] = 0;
            end
            if (!bus_nce[1]) nce_low++;
            if (done1[1]) ndone++;
            if (gnt0[1]) g0_seen++;
        end
        check("rd_nce_cycles", nce_low, 32'd3);
        check("rd_done_count", ndone, 32'd1);
        check("rd_gnt0_never", g0_seen, 32'd0);
        check("rd_rdata_hold", rdata[1], 32'hDEADBEEF);

        // Tie after reset and sustained contention on instance 0
        nrst[0] = 0;
        @(negedge clk);
        nrst[0] = 1;
        @(negedge clk);
        req0[0] = 1; we0[0] = 1; addr0[0] = 11'h020; wdata0[0] = 32'hA0;
        req1[0] = 1; we1[0] = 1; addr1[0] = 11'h030; wdata1[0] = 32'hB1;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 1'(k % 2), 1'b0, 32'h0));
        ndone = 0; ng = 0;
        for (int c = 1; c <= 20 && ndone < 4; c++) begin
            @(negedge clk);
            if ((gnt0[0] || gnt1[0]) && ng < 4) begin
                order[ng] = gnt1[0] ? 1 : 0;
                gcyc[ng]  = c;
                check("tie_addr", {21'd0, bus_addr[0]}, gnt1[0] ? 32'h030 : 32'h020);
                ng++;
            end
            if (done0[0] || done1[0]) ndone++;
            if (ndone == 4) begin
                req0[0] = 0; req1[0] = 0;
            end
        end
        req0[0] = 0; req1[0] = 0;
        check("tie_done_count", ndone, 32'd4);
        check("tie_grant_count", ng, 32'd4);
        for (int k = 0; k < 4; k++) check("tie_order", order[k], k % 2);
        for (int k = 1; k < 4; k++) check("tie_period", gcyc[k] - gcyc[k-1], 32'd3);
        @(negedge clk);
        check("tie_no_fifth", {30'd0, gnt0[0], gnt1[0]}, 32'd0);

        // Late request from master 1 during master 0's transaction
        req0[0] = 1; we0[0] = 1; addr0[0] = 11'h008; wdata0[0] = 32'h11;
        exp_q.push_back(mk(0, 1'b0, 1'b0, 32'h0));
        @(negedge clk);
        check("late_gnt0", {30'd0, gnt0[0], gnt1[0]}, 32'd2);
        req0[0] = 0; addr0[0] = 11'h7FF;
        req1[0] = 1; we1[0] = 1; addr1[0] = 11'h010; wdata1[0] = 32'h22;
        exp_q.push_back(mk(0, 1'b1, 1'b0, 32'h0));
        @(negedge clk);
        check("late_done_addr", {21'd0, bus_addr[0]}, 32'h008);
        check("late_done_gnt1", {31'd0, gnt1[0]}, 32'd0);
        @(negedge clk);
        check("late_idle_addr", {21'd0, bus_addr[0]}, 32'h008);
        check("late_idle_gnt1", {31'd0, gnt1[0]}, 32'd0);
        addr1[0] = 11'h012;
        @(negedge clk);
        check("late_gnt1", {30'd0, gnt0[0], gnt1[0]}, 32'd1);
        check("late_addr1", {21'd0, bus_addr[0]}, 32'h012);
        check("late_data1", bus_data[0], 32'h22);
        req1[0] = 0;
        repeat (3) @(negedge clk);

        // Reset mid-ACCESS, ACCESS_CYCLES=4
        req0[2] = 1; we0[2] = 1; addr0[2] = 11'h005; wdata0[2] = 32'h55;
        @(negedge clk);
        check("mid_gnt0", {31'd0, gnt0[2]}, 32'd1);
        req0[2] = 0;
        @(negedge clk);
        nrst[2] = 0;
        #1;
        check("mid_rst_nce", {31'd0, bus_nce[2]}, 32'd1);
        check("mid_rst_gnt", {30'd0, gnt0[2], gnt1[2]}, 32'd0);
        check("mid_rst_busy", {31'd0, busy[2]}, 32'd0);
        repeat (2) @(negedge clk);
        nrst[2] = 1;
        repeat (6) @(negedge clk);
        req0[2] = 1; req1[2] = 1; addr1[2] = 11'h006;
        exp_q.push_back(mk(2, 1'b0, 1'b0, 32'h0));
        @(negedge clk);
        check("post_rst_tie", {30'd0, gnt0[2], gnt1[2]}, 32'd2);
        check("post_rst_addr", {21'd0, bus_addr[2]}, 32'h005);
        req0[2] = 0; req1[2] = 0;
        repeat (6) @(negedge clk);

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
